// File: rtl/ssf_io_host_if.sv
// Host/processor I/O bundle for ssf_io_host: processor strobes and data,
// host write stream (s_*) and host read stream (m_*).
// The slave modport is the view taken by ssf_io_host itself.
interface ssf_io_host_if #(
    parameter int NUBITS = 32,
    parameter int NUIOIN = 2,
    parameter int NUIOOU = 2
);
    localparam int SPW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int MPW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

    logic [NUIOIN-1:0] req_in;
    logic [NUBITS-1:0] io_in;
    logic [NUIOOU-1:0] out_en;
    logic [NUBITS-1:0] io_out;

    logic [NUBITS-1:0] s_data;
    logic [SPW-1:0]    s_port;
    logic              s_valid;
    logic              s_ready;

    logic [NUBITS-1:0] m_data;
    logic [MPW-1:0]    m_port;
    logic              m_valid;
    logic              m_ready;

    modport slave (
        input  req_in, out_en, io_out, s_data, s_port, s_valid, m_ready,
        output io_in, s_ready, m_data, m_port, m_valid
    );

    modport master (
        output req_in, out_en, io_out, s_data, s_port, s_valid, m_ready,
        input  io_in, s_ready, m_data, m_port, m_valid
    );
endinterface

// File: rtl/ssf_io_host.sv
// Host-side endpoint of the ssf processor I/O protocol.
// One FIFO per processor input port (filled from the host write stream,
// drained by req_in strobes) and one shared, port-tagged output FIFO
// (filled by out_en strobes, drained by the host read stream).
// Optional macro SSF_IO_STATUS_EN adds sticky underflow/overflow flags and
// per-port input FIFO occupancy outputs.
module ssf_io_host #(
    parameter int NUBITS = 32,
    parameter int NUIOIN = 2,
    parameter int NUIOOU = 2,
    parameter int FDEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    ssf_io_host_if.slave io
`ifdef SSF_IO_STATUS_EN
    ,
    output logic [NUIOIN-1:0]                      underflow,
    output logic                                   overflow,
    output logic [NUIOIN*($clog2(FDEPTH)+1)-1:0]   in_level
`endif
);
    localparam int AW  = $clog2(FDEPTH);
    localparam int PW  = AW + 1;
    localparam int SPW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int MPW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

    // ---------------- input FIFOs ----------------
    logic [NUBITS-1:0] in_mem [NUIOIN][FDEPTH];
    logic [PW-1:0]     in_wp  [NUIOIN];
    logic [PW-1:0]     in_rp  [NUIOIN];
    logic [NUIOIN-1:0] in_full, in_empty, in_push, in_pop;
    logic              rd_any;
    logic [SPW-1:0]    rd_sel;

    // ---------------- output FIFO ----------------
    logic [MPW+NUBITS-1:0] out_mem [FDEPTH];
    logic [PW-1:0]         out_wp, out_rp;
    logic                  out_full, out_empty, out_push, out_pop;
    logic                  wr_any;
    logic [MPW-1:0]        wr_sel;

    // Full/empty flags from the extra-MSB pointer comparison.
    always_comb begin
        for (int i = 0; i < NUIOIN; i++) begin
            in_empty[i] = (in_wp[i] == in_rp[i]);
            in_full[i]  = (in_wp[i][AW] != in_rp[i][AW]) &&
                          (in_wp[i][AW-1:0] == in_rp[i][AW-1:0]);
        end
        out_empty = (out_wp == out_rp);
        out_full  = (out_wp[AW] != out_rp[AW]) &&
                    (out_wp[AW-1:0] == out_rp[AW-1:0]);
    end

    // Priority-select the lowest set bit of each processor strobe.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        rd_any = 1'b0;
        rd_sel = '0;
        for (int i = NUIOIN - 1; i >= 0; i--) begin
            if (io.req_in[i]) begin
                rd_any = 1'b1;
                rd_sel = SPW'(i);
            end
        end
        wr_any = 1'b0;
        wr_sel = '0;
        for (int i = NUIOOU - 1; i >= 0; i--) begin
            if (io.out_en[i]) begin
                wr_any = 1'b1;
                wr_sel = MPW'(i);
            end
        end
    end

    // Input side handshake, processor read data and per-port push/pop.
    always_comb begin
        io.s_ready = 1'b0;
        io.io_in   = '0;
        in_push    = '0;
        in_pop     = '0;
        for (int i = 0; i < NUIOIN; i++) begin
            // Ports beyond NUIOIN never match, so they leave s_ready low.
            if (io.s_port == SPW'(i)) begin
                io.s_ready = !in_full[i];
                in_push[i] = io.s_valid && !in_full[i];
            end
            // An empty selected FIFO returns zero and does not pop.
            if (rd_any && (rd_sel == SPW'(i)) && !in_empty[i]) begin
                io.io_in  = in_mem[i][in_rp[i][AW-1:0]];
                in_pop[i] = 1'b1;
            end
        end
    end

    // Output side push/pop; a full FIFO accepts a push only while it pops.
    always_comb begin
        out_pop    = !out_empty && io.m_ready;
        out_push   = wr_any && (!out_full || out_pop);
        io.m_valid = !out_empty;
        if (!out_empty) begin
            {io.m_port, io.m_data} = out_mem[out_rp[AW-1:0]];
        end else begin
            io.m_port = '0;
            io.m_data = '0;
        end
    end

    // Word storage for all FIFOs.
    // NOTE: storage is not reset; the cleared pointers make stale words unreachable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUIOIN; i++) begin
            if (in_push[i]) begin
                in_mem[i][in_wp[i][AW-1:0]] <= io.s_data;
            end
        end
        if (out_push) begin
            out_mem[out_wp[AW-1:0]] <= {wr_sel, io.io_out};
        end
    end

    // Pointer registers; reset empties every FIFO and ignores coincident strobes.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            for (int i = 0; i < NUIOIN; i++) begin
                in_wp[i] <= '0;
                in_rp[i] <= '0;
            end
            out_wp <= '0;
            out_rp <= '0;
        end else begin
            for (int i = 0; i < NUIOIN; i++) begin
                if (in_push[i]) in_wp[i] <= in_wp[i] + PW'(1);
                if (in_pop[i])  in_rp[i] <= in_rp[i] + PW'(1);
            end
            if (out_push) out_wp <= out_wp + PW'(1);
            if (out_pop)  out_rp <= out_rp + PW'(1);
        end
    end

`ifdef SSF_IO_STATUS_EN
    // Sticky event flags: underflow per input port, overflow on a dropped word.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow <= '0;
            overflow  <= 1'b0;
        end else begin
            for (int i = 0; i < NUIOIN; i++) begin
                if (rd_any && (rd_sel == SPW'(i)) && in_empty[i]) begin
                    underflow[i] <= 1'b1;
                end
            end
            if (wr_any && out_full && !out_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Occupancy of each input FIFO, port 0 in the LSBs.
    always_comb begin
        in_level = '0;
        for (int i = 0; i < NUIOIN; i++) begin
            in_level[i*PW +: PW] = in_wp[i] - in_rp[i];
        end
    end
`endif

endmodule

// File: doc/ssf_io_host.md
# ssf_io_host

Host-side endpoint of the ssf processor I/O protocol. It sources input words to the processor's `io_in` when a one-hot `req_in` strobe arrives, and captures `io_out` words when a one-hot `out_en` strobe arrives. Input words are buffered in one FIFO per input port and filled from a host write stream. Output words go into one shared FIFO, each tagged with its port index, and drain to a host read stream. It sits beside the `ssf` top-level, wired to its `io_in`/`io_out`/`req_in`/`out_en`.

## Interface
- NUBITS, 32, data word width (signed two's complement, passed through untouched)
- NUIOIN, 2, number of processor input ports (1..8)
- NUIOOU, 2, number of processor output ports (1..8)
- FDEPTH, 16, depth of each FIFO; power of two, ≥2
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_in  in  NUIOIN  one-hot input-port read strobe from processor
- io_in  out  NUBITS  data to processor
- out_en  in  NUIOOU  one-hot output-port write strobe from processor
- io_out  in  NUBITS  data from processor, valid with out_en
- s_data  in  NUBITS  host write data
- s_port  in  clog2(NUIOIN) (min 1)  target input port
- s_valid  in  1  host write valid
- s_ready  out  1  FIFO of s_port not full
- m_data  out  NUBITS  captured output word
- m_port  out  clog2(NUIOOU) (min 1)  source output port of m_data
- m_valid  out  1  output FIFO not empty
- m_ready  in  1  host read accept

## Operation
- Write side: a word is accepted when `s_valid & s_ready`, and it is pushed into input FIFO `s_port`. An `s_port` ≥ NUIOIN gives `s_ready`=0 and the word is never accepted.
- Processor read:
  - `io_in` is combinational: it carries the head of the FIFO selected by the asserted `req_in` bit.
  - That FIFO pops at the clock edge ending the strobe cycle.
  - If no bit is set, `io_in`=0.
  - If the selected FIFO is empty, `io_in`=0, no pop occurs, and an underflow event is raised.
  - If `req_in` is not one-hot (more than one bit set), the lowest set bit wins.
- Processor write:
  - On an `out_en` bit, {port index, `io_out`} is pushed to the output FIFO in the same edge.
  - Lowest set bit wins on a multi-hot strobe.
  - If the output FIFO is full, the word is dropped and an overflow event is raised.
- Read side: `m_data`/`m_port` show the output FIFO head while `m_valid`=1. The FIFO pops when `m_valid & m_ready`.
- Simultaneous push and pop on one FIFO:
  - Input FIFO, full and popped by `req_in` in the same cycle: `s_ready` stays 0 that cycle (it reflects pre-edge state), so no push happens.
  - Output FIFO, full with `m_ready` pop and `out_en` push in the same cycle: both succeed and occupancy stays constant. This is the only full-state push that is allowed.
  - Empty FIFO: a push and a pop in the same cycle give a pop of nothing. The word is stored and no underflow is flagged on the output side.
- Pointers are log2(FDEPTH)+1 bits and wrap modulo 2·FDEPTH. Full when the MSBs differ and the rest are equal; empty when the pointers are equal.

## Timing
- Reset (`rst`=1 at an edge):
  - All pointers cleared, all FIFOs empty.
  - Outputs: `io_in`=0, `s_ready`=1 for valid ports, `m_valid`=0, `m_data`=0, `m_port`=0.
  - Status cleared.
  - FIFO contents are not cleared but are unreachable.
- Reset asserted mid-stream discards all buffered words. A strobe coinciding with `rst` is ignored.
- Latencies:
  - Host write to `io_in` visibility: 1 cycle (the word pushed at edge N is readable by `req_in` in cycle N+1).
  - `out_en` to `m_valid`: 1 cycle.
  - Pop to new head: next cycle.
- Sustained throughput is one word per cycle per direction.

## Configuration
- Macro `SSF_IO_STATUS_EN`.
- Defined: the block adds the following outputs.
  - `underflow` (NUIOIN, sticky per input port).
  - `overflow` (1, sticky).
  - `in_level` (NUIOIN·(log2(FDEPTH)+1), concatenated occupancies, port 0 in LSBs).
  - Sticky bits set on the event edge and clear only on `rst`.
- Undefined: these ports and their logic are absent. Underflow still returns 0 and overflow still drops the word.

## Test plan
- Reset then idle: `rst` 2 cycles → `m_valid`=0, `io_in`=0, `s_ready`=1, `overflow`=0.
- Host writes 0x11, 0x22 to port 0 and 0x33 to port 1. Next cycle `req_in`=01 → `io_in`=0x11. Then `req_in`=10 → `io_in`=0x33. Then `req_in`=01 → `io_in`=0x22.
- `req_in`=10 on empty port 1 → `io_in`=0, `underflow`[1]=1, port 0 occupancy unchanged.
- Write 16 words to port 0 → `s_ready`=0 with `s_port`=0 and 1 with `s_port`=1. A 17th write is not accepted. After one `req_in` pop, `s_ready`=1 the following cycle.
- `out_en`=10 with `io_out`=-5 (0xFFFFFFFB) and `m_ready`=0 → next cycle `m_valid`=1, `m_data`=0xFFFFFFFB, `m_port`=1.
- Fill the output FIFO to 16 with `m_ready`=0, then `out_en` → word dropped, `overflow`=1. With FIFO full, `out_en` and `m_ready` in the same cycle → level stays 16 and the new word appears last in drain order. Assert `rst` mid-drain → `m_valid`=0 next cycle.
